// File: rtl/usb_rx_bit_decoder.sv
// Full-speed USB receive front end: edge-resynced oversampling, NRZI decode, bit destuffing, EOP/SE1 detection.
// Every strobe is registered one clk after its sample cycle; there is no backpressure, so downstream must accept every strobe.
module usb_rx_bit_decoder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus_sync,
   input  logic d_minus_sync,
   input  logic enable,
   output logic bit_out,
   output logic bit_valid,
   output logic eop,
   output logic stuff_err,
   output logic se1_err
);

   localparam int                PH_W      = $clog2(CLKS_PER_BIT);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
   localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_POINT);
   localparam logic [2:0]        STUFF_RUN = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_SE0_1  = 2'd2,
      ST_SE0_2  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      LN_SE0 = 2'b00,
      LN_K   = 2'b01,
      LN_J   = 2'b10,
      LN_SE1 = 2'b11
   } line_t;

   state_t          state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            prev_j_q, prev_j_d;
   logic [2:0]      ones_q, ones_d;
   logic            dp_prev_q;

   logic            bit_out_q, bit_out_d;
   logic            bit_valid_q, bit_valid_d;
   logic            eop_q, eop_d;
   logic            stuff_err_q, stuff_err_d;
   logic            se1_err_q, se1_err_d;

   logic            line_edge;
   logic [PH_W-1:0] eff_phase;
   logic [PH_W-1:0] phase_inc;
   logic            sample;
   line_t           line_st;
   logic            nrzi_bit;

   // Any D+ transition restarts the bit-time count so the sample stays a fixed distance after the edge.
   assign line_edge = (d_plus_sync != dp_prev_q);
   assign eff_phase = line_edge ? '0 : phase_q;
   assign phase_inc = (eff_phase == PH_LAST) ? '0 : eff_phase + PH_W'(1);
   assign sample    = (eff_phase == PH_SAMPLE) && (state_q != ST_IDLE);
   assign line_st   = line_t'({d_plus_sync, d_minus_sync});
   // For J/K only D+ matters: an unchanged level decodes as 1.
   assign nrzi_bit  = (d_plus_sync == prev_j_q);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_inc;
      prev_j_d    = prev_j_q;
      ones_d      = ones_q;
      bit_out_d   = 1'b0;
      bit_valid_d = 1'b0;
      eop_d       = 1'b0;
      stuff_err_d = 1'b0;
      se1_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && line_edge && !d_plus_sync) begin
               state_d = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (sample) begin
               case (line_st)
                  LN_J, LN_K: begin
                     prev_j_d = d_plus_sync;
                     if (ones_q == STUFF_RUN) begin
                        ones_d      = '0;
                        stuff_err_d = nrzi_bit;
                     end else begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = nrzi_bit;
                        ones_d      = nrzi_bit ? ones_q + 3'd1 : '0;
                     end
                  end
                  LN_SE0: begin
                     state_d = ST_SE0_1;
                  end
                  LN_SE1: begin
                     se1_err_d = 1'b1;
                     state_d   = ST_IDLE;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end
         end

         ST_SE0_1: begin
            if (sample) begin
               case (line_st)
                  LN_SE0: state_d = ST_SE0_2;
                  LN_SE1: begin
                     se1_err_d = 1'b1;
                     state_d   = ST_IDLE;
                  end
                  // A lone SE0 followed by J/K is a glitch: drop the packet quietly.
                  default: state_d = ST_IDLE;
               endcase
            end
         end

         ST_SE0_2: begin
            if (sample) begin
               case (line_st)
                  LN_SE0: state_d = ST_SE0_2;
                  LN_J: begin
                     eop_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
                  default: begin
                     se1_err_d = 1'b1;
                     state_d   = ST_IDLE;
                  end
               endcase
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (!enable) begin
         state_d     = ST_IDLE;
         bit_out_d   = 1'b0;
         bit_valid_d = 1'b0;
         eop_d       = 1'b0;
         stuff_err_d = 1'b0;
         se1_err_d   = 1'b0;
      end

      // Entering or staying in IDLE re-arms the decoder for a fresh J->K start.
      if (state_d == ST_IDLE) begin
         phase_d  = '0;
         prev_j_d = 1'b1;
         ones_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         prev_j_q    <= 1'b1;
         ones_q      <= '0;
         dp_prev_q   <= 1'b1;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         eop_q       <= 1'b0;
         stuff_err_q <= 1'b0;
         se1_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         prev_j_q    <= prev_j_d;
         ones_q      <= ones_d;
         dp_prev_q   <= d_plus_sync;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         eop_q       <= eop_d;
         stuff_err_q <= stuff_err_d;
         se1_err_q   <= se1_err_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign eop       = eop_q;
   assign stuff_err = stuff_err_q;
   assign se1_err   = se1_err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboarded bench: per-clock line waveforms are built, a reference model predicts every strobe and its cycle.
module tb_usb_rx_bit_decoder;

   localparam int CPB = 8;
   localparam int SP  = 3;
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] SE1 = 2'b11;

   logic clk = 1'b0;
   logic n_rst, d_plus_sync, d_minus_sync, enable;
   logic bit_out, bit_valid, eop, stuff_err, se1_err;

   usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
      .clk(clk), .n_rst(n_rst), .d_plus_sync(d_plus_sync), .d_minus_sync(d_minus_sync),
      .enable(enable), .bit_out(bit_out), .bit_valid(bit_valid), .eop(eop),
      .stuff_err(stuff_err), .se1_err(se1_err)
   );

   always #5 clk = ~clk;

   // kind: 0 data bit, 1 eop, 2 stuff_err, 3 se1_err
   typedef struct { int kind; int val; int cyc; } ev_t;
   ev_t exp_q[$];
   bit  q_dp[$], q_dm[$], q_en[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every strobe pops the oldest expectation.
   always @(negedge clk) begin : mon
      int   k;
      ev_t  e;
      if (n_rst && (bit_valid || eop || stuff_err || se1_err)) begin
         k = bit_valid ? 0 : eop ? 1 : stuff_err ? 2 : 3;
         check("single_strobe", int'(bit_valid) + int'(eop) + int'(stuff_err) + int'(se1_err), 1);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe_kind", k, -1);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", k, e.kind);
            check("strobe_cycle", cyc, e.cyc);
            if (e.kind == 0) check("bit_out", int'(bit_out), e.val);
         end
      end
   end

   task automatic push(input int k, input int v, input int c);
      exp_q.push_back('{k, v, c});
   endtask

   task automatic add_sym(input logic [1:0] s, input int dur, input bit en);
      for (int i = 0; i < dur; i++) begin
         q_dp.push_back(s[1]);
         q_dm.push_back(s[0]);
         q_en.push_back(en);
      end
   endtask

   // Reference: sample 3 clks after the latest D+ transition and every bit time after,
   // then decode the sampled symbol stream (NRZI, six-ones stuffing, SE0 runs).
   task automatic model(input int c0);
      bit         active, prev_j, pdp, bt, edge_t;
      int         ones, se0_run, last_edge;
      logic [1:0] s;
      active = 0; prev_j = 1; pdp = 1; ones = 0; se0_run = 0; last_edge = 0;
      for (int t = 0; t < q_dp.size(); t++) begin
         s      = {q_dp[t], q_dm[t]};
         edge_t = (q_dp[t] != pdp);
         pdp    = q_dp[t];
         if (edge_t) last_edge = t;
         if (!q_en[t]) begin
            active = 0;
         end else if (!active) begin
            if (edge_t && !q_dp[t]) begin
               active = 1; prev_j = 1; ones = 0; se0_run = 0;
            end
         end else if ((t - last_edge) % CPB == SP) begin
            if (s == SE1) begin
               push(3, 0, c0 + t + 1);
               active = 0;
            end else if (s == SE0) begin
               se0_run++;
            end else if (se0_run > 0) begin
               if (se0_run >= 2) push((s == J) ? 1 : 3, 0, c0 + t + 1);
               active = 0;
            end else begin
               bt     = (q_dp[t] == prev_j);
               prev_j = q_dp[t];
               if (ones == 6) begin
                  if (bt) push(2, 0, c0 + t + 1);
                  ones = 0;
               end else begin
                  push(0, int'(bt), c0 + t + 1);
                  ones = bt ? ones + 1 : 0;
               end
            end
         end
      end
   endtask

   task automatic run_seq();
      int c0;
      @(negedge clk);
      c0 = cyc;
      model(c0);
      for (int i = 0; i < q_dp.size(); i++) begin
         if (i > 0) @(negedge clk);
         d_plus_sync  = q_dp[i];
         d_minus_sync = q_dm[i];
         enable       = q_en[i];
      end
      q_dp.delete(); q_dm.delete(); q_en.delete();
   endtask

   task automatic finish_seq(input string name);
      repeat (3) @(negedge clk);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   function automatic int jdur(input bit jit);
      int r;
      r = $urandom_range(0, 3);
      if (!jit || r > 1) return 8;
      return (r == 0) ? 6 : 10;
   endfunction

   task automatic add_sync(input bit jit);
      logic [1:0] seq [8];
      seq = '{K, J, K, J, K, J, K, K};
      foreach (seq[i]) add_sym(seq[i], jdur(jit), 1'b1);
   endtask

   task automatic add_tail();
      add_sym(J, 6, 1'b1);
      add_sym(J, 2, 1'b0);
   endtask

   task automatic add_eop();
      add_sym(SE0, 8, 1'b1);
      add_sym(SE0, 8, 1'b1);
      add_sym(J, 8, 1'b1);
   endtask

   task automatic rand_packet();
      logic [1:0] lvl;
      int ones, nb, endk, pos, len;
      bit nostuff, b;
      add_sym(J, 6, 1'b1);
      add_sync(1'b1);
      lvl = K; ones = 1;
      nb = $urandom_range(8, 40);
      nostuff = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < nb; i++) begin
         b = ($urandom_range(0, 9) < 7);
         if (!b) lvl = ~lvl;
         add_sym(lvl, jdur(1'b1), 1'b1);
         ones = b ? ones + 1 : 0;
         if (ones == 6 && !nostuff) begin
            lvl = ~lvl;
            add_sym(lvl, jdur(1'b1), 1'b1);
            ones = 0;
         end
      end
      endk = $urandom_range(0, 9);
      if (endk < 7) begin
         add_eop();
      end else if (endk == 7) begin
         add_sym(SE0, 8, 1'b1); add_sym(J, 8, 1'b1);
      end else if (endk == 8) begin
         add_sym(SE1, 8, 1'b1);
      end else begin
         add_sym(SE0, 8, 1'b1); add_sym(SE0, 8, 1'b1); add_sym(SE0, 8, 1'b1); add_sym(K, 8, 1'b1);
      end
      add_tail();
      if ($urandom_range(0, 6) == 0) begin
         pos = $urandom_range(8, q_en.size() - 10);
         len = $urandom_range(3, 12);
         for (int k = pos; k < pos + len && k < q_en.size(); k++) q_en[k] = 1'b0;
      end
   endtask

   initial begin
      n_rst = 1'b0; d_plus_sync = 1'b1; d_minus_sync = 1'b0; enable = 1'b0;
      #1;
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_eop", int'(eop), 0);
      check("rst_stuff_err", int'(stuff_err), 0);
      check("rst_se1_err", int'(se1_err), 0);
      check("rst_bit_out", int'(bit_out), 0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;

      // SYNC alone
      add_sym(J, 4, 1'b1); add_sync(1'b0); add_tail();
      run_seq(); finish_seq("sync_drained");

      // run of ones with a correct stuff bit, then EOP
      add_sym(J, 4, 1'b1); add_sync(1'b0);
      repeat (5) add_sym(K, 8, 1'b1);
      add_sym(J, 8, 1'b1); add_sym(K, 8, 1'b1);
      add_eop(); add_tail();
      run_seq(); finish_seq("stuff_ok_drained");

      // stuffing violation: line held at K
      add_sym(J, 4, 1'b1); add_sync(1'b0);
      repeat (7) add_sym(K, 8, 1'b1);
      add_sym(J, 8, 1'b1);
      add_eop(); add_tail();
      run_seq(); finish_seq("stuff_err_drained");

      // stray edges with receiver disarmed
      add_sym(J, 4, 1'b0);
      add_sym(K, 8, 1'b0); add_sym(J, 8, 1'b0); add_sym(K, 8, 1'b0); add_sym(J, 8, 1'b0);
      run_seq(); finish_seq("disabled_drained");

      // early and late edges
      add_sym(J, 4, 1'b1);
      add_sym(K, 8, 1'b1); add_sym(J, 6, 1'b1); add_sym(K, 10, 1'b1); add_sym(J, 6, 1'b1);
      add_sym(K, 10, 1'b1); add_sym(J, 8, 1'b1); add_sym(K, 8, 1'b1); add_sym(K, 8, 1'b1);
      add_sym(J, 10, 1'b1); add_sym(K, 6, 1'b1);
      add_eop(); add_tail();
      run_seq(); finish_seq("jitter_drained");

      // enable dropped mid-packet
      add_sym(J, 4, 1'b1); add_sync(1'b0);
      add_sym(J, 8, 1'b1); add_sym(K, 8, 1'b0); add_sym(K, 8, 1'b0);
      add_sym(SE0, 16, 1'b0); add_sym(J, 8, 1'b0);
      run_seq(); finish_seq("en_drop_drained");

      // async reset while a strobe is showing
      add_sym(J, 4, 1'b1);
      add_sym(K, 8, 1'b1); add_sym(J, 8, 1'b1); add_sym(K, 8, 1'b1); add_sym(J, 5, 1'b1);
      run_seq();
      check("pre_reset_valid", int'(bit_valid), 1);
      #1 n_rst = 1'b0;
      #1;
      check("async_rst_bit_valid", int'(bit_valid), 0);
      check("async_rst_bit_out", int'(bit_out), 0);
      check("async_rst_errs", int'(eop) + int'(stuff_err) + int'(se1_err), 0);
      check("reset_drained", exp_q.size(), 0);
      d_plus_sync = 1'b1; d_minus_sync = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      add_sym(J, 4, 1'b1); add_sync(1'b0); add_tail();
      run_seq(); finish_seq("post_reset_sync_drained");

      for (int p = 0; p < 60; p++) begin
         rand_packet();
         run_seq();
         finish_seq("rand_drained");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
